store_drain_buffer: RTL and testbench

//  Write-side companion of the read-memory pipeline stage: buffers committed stores
//  and retires them in order to the data-memory write port over a req/ack handshake.

---
 rtl/store_drain_buffer.sv | 150 +++++++++++++++
 tb/tb_store_drain_buffer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_drain_buffer.sv
// In-order store buffer that retires committed stores to the data-memory write port
// and supports a fence/drain sequence. Store-to-load forwarding is built when STORE_FWD_EN is defined.
//
// state | meaning
// ------+---------------------------------------------------------------
// RUN   | normal operation, stores accepted while not full
// DRAIN | fence pending, stores blocked until the buffer is empty
// DONE  | buffer drained, fence_done high for this single cycle
module store_drain_buffer #(
  parameter int ADDR_WIDTH = 30,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         st_valid,
  output logic                         st_ready,
  input  logic [ADDR_WIDTH-1:0]        st_addr,
  input  logic [DATA_WIDTH-1:0]        st_data,
  input  logic [DATA_WIDTH/8-1:0]      st_be,
  output logic                         mem_wr_req,
  output logic [ADDR_WIDTH-1:0]        mem_wr_addr,
  output logic [DATA_WIDTH-1:0]        mem_wr_data,
  output logic [DATA_WIDTH/8-1:0]      mem_wr_be,
  input  logic                         mem_wr_ack,
  input  logic                         fence_req,
  output logic                         fence_done,
  input  logic                         ld_valid,
  input  logic [ADDR_WIDTH-1:0]        ld_addr,
  output logic [DATA_WIDTH/8-1:0]      ld_fwd_be,
  output logic [DATA_WIDTH-1:0]        ld_fwd_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int BW = DATA_WIDTH / 8;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t state;
  logic   rdy_en;

  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic [BW-1:0]         be_mem   [DEPTH];

  logic push;
  logic pop;

  // rdy_en keeps st_ready low until the first edge after reset release.
  assign st_ready = rdy_en & (count < DEPTH_C) & (state == S_RUN);
  assign push     = st_valid & st_ready;

  assign mem_wr_req  = (count != '0);
  assign mem_wr_addr = addr_mem[head];
  assign mem_wr_data = data_mem[head];
  assign mem_wr_be   = be_mem[head];
  assign pop         = mem_wr_req & mem_wr_ack;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry contents need no reset; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail] <= st_addr;
      data_mem[tail] <= st_data;
      be_mem[tail]   <= st_be;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_RUN;
      fence_done <= 1'b0;
      rdy_en     <= 1'b0;
    end else begin
      rdy_en     <= 1'b1;
      fence_done <= 1'b0;
      case (state)
        S_RUN: begin
          // A store accepted alongside the fence must still be drained.
          if (fence_req) begin
            if ((count == '0) && !push) begin
              state      <= S_DONE;
              fence_done <= 1'b1;
            end else begin
              state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (count == '0) begin
            state      <= S_DONE;
            fence_done <= 1'b1;
          end
        end
        S_DONE:  state <= S_RUN;
        default: state <= S_RUN;
      endcase
    end
  end

`ifdef STORE_FWD_EN
  // Walk entries oldest to youngest so younger matches overwrite per byte.
  always_comb begin
    ld_fwd_be   = '0;
    ld_fwd_data = '0;
    if (ld_valid) begin
      for (int off = 0; off < DEPTH; off++) begin
        if ((CW'(off) < count) && (addr_mem[head + PW'(off)] == ld_addr)) begin
          for (int b = 0; b < BW; b++) begin
            if (be_mem[head + PW'(off)][b]) begin
              ld_fwd_be[b]         = 1'b1;
              ld_fwd_data[8*b +: 8] = data_mem[head + PW'(off)][8*b +: 8];
            end
          end
        end
      end
    end
  end
`else
  logic ld_unused;
  assign ld_unused   = ^{ld_valid, ld_addr};
  assign ld_fwd_be   = '0;
  assign ld_fwd_data = '0;
`endif

endmodule

// File: tb/tb_store_drain_buffer.sv
// Directed, table-driven bench for store_drain_buffer (forwarding checks follow STORE_FWD_EN).
module tb_store_drain_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic        st_ready;
  logic [29:0] st_addr;
  logic [31:0] st_data;
  logic [3:0]  st_be;
  logic        mem_wr_req;
  logic [29:0] mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic [3:0]  mem_wr_be;
  logic        mem_wr_ack;
  logic        fence_req;
  logic        fence_done;
  logic        ld_valid;
  logic [29:0] ld_addr;
  logic [3:0]  ld_fwd_be;
  logic [31:0] ld_fwd_data;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  store_drain_buffer dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data), .st_be(st_be),
    .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_be(mem_wr_be), .mem_wr_ack(mem_wr_ack),
    .fence_req(fence_req), .fence_done(fence_done),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_fwd_be(ld_fwd_be), .ld_fwd_data(ld_fwd_data),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st_valid;
    logic [29:0] st_addr;
    logic        ack;
    logic [2:0]  exp_count;
    logic        exp_ready;
    logic        exp_req;
    logic [29:0] exp_addr;
  } vec_t;

  vec_t vecs [20];

  function automatic vec_t mk(input logic v, input logic [29:0] a, input logic ack,
                              input logic [2:0] c, input logic r, input logic q,
                              input logic [29:0] ea);
    vec_t t;
    t.st_valid = v; t.st_addr = a; t.ack = ack;
    t.exp_count = c; t.exp_ready = r; t.exp_req = q; t.exp_addr = ea;
    return t;
  endfunction

  function automatic logic [31:0] data_of(input logic [29:0] a);
    return 32'hD000_0000 | {2'b00, a};
  endfunction

  function automatic logic [3:0] be_of(input logic [29:0] a);
    case (a[1:0])
      2'd0:    return 4'b1111;
      2'd1:    return 4'b0011;
      2'd2:    return 4'b1100;
      default: return 4'b0001;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    st_valid = 1'b0; st_addr = '0; st_data = '0; st_be = '0;
    mem_wr_ack = 1'b0; fence_req = 1'b0; ld_valid = 1'b0; ld_addr = '0;
  endtask

  task automatic push_one(input logic [29:0] a, input logic [31:0] d, input logic [3:0] be);
    st_valid = 1'b1; st_addr = a; st_data = d; st_be = be;
    cyc();
    st_valid = 1'b0;
  endtask

  initial begin
    int w, zc, done_at, done_n;
    logic [3:0]  exp_be;
    logic [31:0] exp_data;

    vecs[0]  = mk(1, 30'h10, 0, 3'd0, 1, 0, 30'h0);
    vecs[1]  = mk(1, 30'h11, 0, 3'd1, 1, 1, 30'h10);
    vecs[2]  = mk(1, 30'h12, 0, 3'd2, 1, 1, 30'h10);
    vecs[3]  = mk(1, 30'h13, 0, 3'd3, 1, 1, 30'h10);
    vecs[4]  = mk(1, 30'h14, 0, 3'd4, 0, 1, 30'h10);
    vecs[5]  = mk(0, 30'h0,  1, 3'd4, 0, 1, 30'h10);
    vecs[6]  = mk(0, 30'h0,  1, 3'd3, 1, 1, 30'h11);
    vecs[7]  = mk(0, 30'h0,  1, 3'd2, 1, 1, 30'h12);
    vecs[8]  = mk(0, 30'h0,  1, 3'd1, 1, 1, 30'h13);
    vecs[9]  = mk(0, 30'h0,  0, 3'd0, 1, 0, 30'h0);
    vecs[10] = mk(1, 30'h30, 0, 3'd0, 1, 0, 30'h0);
    vecs[11] = mk(1, 30'h31, 0, 3'd1, 1, 1, 30'h30);
    vecs[12] = mk(1, 30'h32, 1, 3'd2, 1, 1, 30'h30);
    vecs[13] = mk(0, 30'h0,  0, 3'd2, 1, 1, 30'h31);
    vecs[14] = mk(0, 30'h0,  1, 3'd2, 1, 1, 30'h31);
    vecs[15] = mk(0, 30'h0,  1, 3'd1, 1, 1, 30'h32);
    vecs[16] = mk(0, 30'h0,  1, 3'd0, 1, 0, 30'h0);
    vecs[17] = mk(1, 30'h40, 0, 3'd0, 1, 0, 30'h0);
    vecs[18] = mk(0, 30'h0,  1, 3'd1, 1, 1, 30'h40);
    vecs[19] = mk(0, 30'h0,  0, 3'd0, 1, 0, 30'h0);

    idle();
    rst = 1'b0;
    cyc(); cyc();
    chk("rst_ready", st_ready, 0);
    chk("rst_req", mem_wr_req, 0);
    chk("rst_count", count, 0);
    chk("rst_fence_done", fence_done, 0);
    chk("rst_fwd_be", ld_fwd_be, 0);
    @(negedge clk);
    rst = 1'b1;
    cyc();

    for (int i = 0; i < 20; i++) begin
      st_valid = vecs[i].st_valid;
      st_addr  = vecs[i].st_addr;
      st_data  = data_of(vecs[i].st_addr);
      st_be    = be_of(vecs[i].st_addr);
      mem_wr_ack = vecs[i].ack;
      #1;
      chk($sformatf("vec%0d_count", i), count, vecs[i].exp_count);
      chk($sformatf("vec%0d_ready", i), st_ready, vecs[i].exp_ready);
      chk($sformatf("vec%0d_req", i), mem_wr_req, vecs[i].exp_req);
      if (vecs[i].exp_req) begin
        chk($sformatf("vec%0d_addr", i), mem_wr_addr, vecs[i].exp_addr);
        chk($sformatf("vec%0d_data", i), mem_wr_data, data_of(vecs[i].exp_addr));
        chk($sformatf("vec%0d_be", i), mem_wr_be, be_of(vecs[i].exp_addr));
      end
      cyc();
    end
    idle();

    // head held stable while ack withheld
    push_one(30'h60, 32'hCAFE_F00D, 4'b0101);
    for (int i = 0; i < 3; i++) begin
      mem_wr_ack = 1'b0;
      #1;
      chk("hold_req", mem_wr_req, 1);
      chk("hold_addr", mem_wr_addr, 30'h60);
      chk("hold_data", mem_wr_data, 32'hCAFE_F00D);
      chk("hold_be", mem_wr_be, 4'b0101);
      cyc();
    end
    mem_wr_ack = 1'b1;
    cyc();
    mem_wr_ack = 1'b0;
    #1;
    chk("hold_empty_req", mem_wr_req, 0);
    chk("hold_empty_count", count, 0);
    cyc();

    // fence with two entries, ack after two wait cycles per entry
    push_one(30'h50, 32'h5050_5050, 4'b1111);
    push_one(30'h51, 32'h5151_5151, 4'b1111);
    fence_req = 1'b1;
    #1;
    chk("fence_start_count", count, 2);
    cyc();
    fence_req = 1'b0;
    w = 0; zc = -1; done_at = -1; done_n = 0;
    for (int i = 0; i < 30 && done_n == 0; i++) begin
      if (mem_wr_req) begin
        if (w == 2) begin mem_wr_ack = 1'b1; w = 0; end
        else begin mem_wr_ack = 1'b0; w++; end
      end else begin
        mem_wr_ack = 1'b0;
      end
      #1;
      if (count == 0 && zc < 0) zc = i;
      if (fence_done) begin done_n++; done_at = i; end
      chk("fence_ready_low", st_ready, 0);
      cyc();
    end
    mem_wr_ack = 1'b0;
    chk("fence_done_seen", done_n, 1);
    chk("fence_done_timing", done_at, zc + 1);
    for (int i = 0; i < 3; i++) begin
      #1;
      if (fence_done) done_n++;
      if (i == 0) chk("fence_ready_after", st_ready, 1);
      cyc();
    end
    chk("fence_single_pulse", done_n, 1);

    // fence on empty buffer
    fence_req = 1'b1;
    #1;
    cyc();
    fence_req = 1'b0;
    #1;
    chk("fence_empty_done", fence_done, 1);
    chk("fence_empty_ready", st_ready, 0);
    cyc();
    #1;
    chk("fence_empty_done_off", fence_done, 0);
    chk("fence_empty_ready_back", st_ready, 1);
    cyc();

    // forwarding lookup
    push_one(30'h20, 32'h1122_3344, 4'b1111);
    push_one(30'h20, 32'hAABB_CCDD, 4'b0011);
    ld_valid = 1'b1; ld_addr = 30'h20;
    #1;
`ifdef STORE_FWD_EN
    exp_be = 4'b1111; exp_data = 32'h1122_CCDD;
`else
    exp_be = 4'b0000; exp_data = 32'h0;
`endif
    chk("fwd_be", ld_fwd_be, exp_be);
    chk("fwd_data", ld_fwd_data, exp_data);
    ld_addr = 30'h21;
    #1;
    chk("fwd_miss_be", ld_fwd_be, 0);
    chk("fwd_miss_data", ld_fwd_data, 0);
    ld_addr = 30'h20;
    st_valid = 1'b1; st_addr = 30'h20; st_data = 32'h9999_9999; st_be = 4'b1111;
    #1;
    chk("fwd_push_excl_data", ld_fwd_data, exp_data);
    cyc();
    st_valid = 1'b0;
    #1;
`ifdef STORE_FWD_EN
    exp_data = 32'h9999_9999;
`endif
    chk("fwd_youngest_data", ld_fwd_data, exp_data);
    ld_valid = 1'b0;
    #1;
    chk("fwd_idle_be", ld_fwd_be, 0);
    mem_wr_ack = 1'b1;
    cyc(); cyc(); cyc();
    mem_wr_ack = 1'b0;
    #1;
    chk("fwd_drained", count, 0);
    cyc();

    // async reset mid-burst
    push_one(30'h70, 32'h7070_7070, 4'b1111);
    push_one(30'h71, 32'h7171_7171, 4'b1111);
    push_one(30'h72, 32'h7272_7272, 4'b1111);
    mem_wr_ack = 1'b1;
    #2;
    chk("pre_rst_count", count, 3);
    rst = 1'b0;
    #1;
    chk("arst_req", mem_wr_req, 0);
    chk("arst_count", count, 0);
    chk("arst_ready", st_ready, 0);
    mem_wr_ack = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rel_ready_low", st_ready, 0);
    cyc();
    chk("rel_ready_high", st_ready, 1);
    chk("rel_count", count, 0);
    chk("rel_req", mem_wr_req, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
